// File: rtl/ace_mem_slave_if.sv
// ACE read (AR/R) and write (AW/W/B) channel bundle between the cache master
// port and ace_mem_slave.
interface ace_mem_slave_if #(
  parameter int WIDTH_A = 32,
  parameter int WIDTH_D = 32
);
  logic               AR_VALID;
  logic               AR_READY;
  logic [WIDTH_A-1:0] AR_ADDR;
  logic               AR_ID;
  logic [7:0]         AR_LEN;
  logic [1:0]         AR_BURST;
  logic [3:0]         AR_SNOOP;
  logic               R_VALID;
  logic               R_READY;
  logic [WIDTH_D-1:0] RDATA;
  logic [3:0]         RRESP;
  logic               R_LAST;
  logic               R_ID;
  logic               AW_VALID;
  logic               AW_READY;
  logic [WIDTH_A-1:0] AW_ADDR;
  logic               AW_ID;
  logic [7:0]         AW_LEN;
  logic [1:0]         AW_BURST;
  logic [2:0]         AW_SNOOP;
  logic               W_VALID;
  logic               W_READY;
  logic [WIDTH_D-1:0] W_DATA;
  logic               W_LAST;
  logic               B_VALID;
  logic               B_READY;
  logic [1:0]         BRESP;

  modport slave (
    input  AR_VALID, AR_ADDR, AR_ID, AR_LEN, AR_BURST, AR_SNOOP, R_READY,
           AW_VALID, AW_ADDR, AW_ID, AW_LEN, AW_BURST, AW_SNOOP,
           W_VALID, W_DATA, W_LAST, B_READY,
    output AR_READY, R_VALID, RDATA, RRESP, R_LAST, R_ID,
           AW_READY, W_READY, B_VALID, BRESP
  );

  modport master (
    output AR_VALID, AR_ADDR, AR_ID, AR_LEN, AR_BURST, AR_SNOOP, R_READY,
           AW_VALID, AW_ADDR, AW_ID, AW_LEN, AW_BURST, AW_SNOOP,
           W_VALID, W_DATA, W_LAST, B_READY,
    input  AR_READY, R_VALID, RDATA, RRESP, R_LAST, R_ID,
           AW_READY, W_READY, B_VALID, BRESP
  );
endinterface

// File: rtl/ace_mem_slave.sv
// ACE memory target: independent read and write FSMs over one word array.
// Define ACE_MEM_ADDR_CHECK_EN to answer out-of-range bursts with SLVERR.
module ace_mem_slave #(
  parameter int WIDTH_A     = 32,
  parameter int WIDTH_D     = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int RD_LATENCY  = 2
) (
  input  logic          clk,
  input  logic          rst,
  ace_mem_slave_if.slave bus
);
  localparam int IDXW = $clog2(DEPTH_WORDS);
  localparam int LATW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [WIDTH_D-1:0] mem [DEPTH_WORDS];

  r_state_t           r_state, r_state_nxt;
  logic [IDXW-1:0]    r_idx, r_idx_nxt, r_rd_idx;
  logic [7:0]         r_len, r_cnt;
  logic [LATW-1:0]    lat_cnt;
  logic               r_fixed, r_id, r_oob, r_last, r_load, r_adv;
  logic [WIDTH_D-1:0] rdata;
  logic [3:0]         rresp;

  w_state_t           w_state, w_state_nxt;
  logic [IDXW-1:0]    w_idx;
  logic [7:0]         w_len, w_cnt;
  logic               w_fixed, w_oob, w_err, w_fire, w_final;

  logic               ar_oob, aw_oob;

`ifdef ACE_MEM_ADDR_CHECK_EN
  assign ar_oob = |bus.AR_ADDR[WIDTH_A-1:IDXW+2];
  assign aw_oob = |bus.AW_ADDR[WIDTH_A-1:IDXW+2];
`else
  assign ar_oob = 1'b0;
  assign aw_oob = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{bus.AR_SNOOP, bus.AW_SNOOP, bus.AW_ID,
                       bus.AR_ADDR[1:0], bus.AW_ADDR[1:0],
                       bus.AR_ADDR[WIDTH_A-1:IDXW+2], bus.AW_ADDR[WIDTH_A-1:IDXW+2]};

  // ---------------- read path ----------------
  assign r_last    = (r_cnt == r_len);
  assign r_idx_nxt = r_fixed ? r_idx : r_idx + 1'b1;
  // The first beat reads the latched start index; later beats read ahead of the index update.
  assign r_rd_idx  = r_adv ? r_idx_nxt : r_idx;

  always_comb begin
    r_state_nxt = r_state;
    r_load      = 1'b0;
    r_adv       = 1'b0;
    case (r_state)
      R_IDLE: if (bus.AR_VALID) r_state_nxt = R_WAIT;
      R_WAIT: if (lat_cnt == '0) begin
        r_load      = 1'b1;
        r_state_nxt = R_DATA;
      end
      R_DATA: if (bus.R_READY) begin
        if (r_last) begin
          r_state_nxt = R_IDLE;
        end else begin
          r_load = 1'b1;
          r_adv  = 1'b1;
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_idx   <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      lat_cnt <= '0;
      r_fixed <= 1'b0;
      r_id    <= 1'b0;
      r_oob   <= 1'b0;
      rdata   <= '0;
      rresp   <= '0;
    end else begin
      r_state <= r_state_nxt;
      if (r_state == R_IDLE && bus.AR_VALID) begin
        r_idx   <= bus.AR_ADDR[IDXW+1:2];
        r_len   <= bus.AR_LEN;
        r_fixed <= (bus.AR_BURST == 2'b00);
        r_id    <= bus.AR_ID;
        r_oob   <= ar_oob;
        r_cnt   <= '0;
        lat_cnt <= LATW'(RD_LATENCY - 1);
      end else if (r_state == R_WAIT && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (r_adv) begin
        r_idx <= r_idx_nxt;
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_load) begin
        rdata <= r_oob ? '0 : mem[r_rd_idx];
        rresp <= r_oob ? 4'b0010 : 4'b0000;
      end
    end
  end

  assign bus.AR_READY = (r_state == R_IDLE);
  assign bus.R_VALID  = (r_state == R_DATA);
  assign bus.RDATA    = rdata;
  assign bus.RRESP    = rresp;
  assign bus.R_LAST   = (r_state == R_DATA) && r_last;
  assign bus.R_ID     = r_id;

  // ---------------- write path ----------------
  assign w_fire  = (w_state == W_DATA) && bus.W_VALID;
  assign w_final = (w_cnt == w_len);

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (bus.AW_VALID) w_state_nxt = W_DATA;
      W_DATA:  if (w_fire && w_final) w_state_nxt = W_RESP;
      W_RESP:  if (bus.B_READY) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_fixed <= 1'b0;
      w_oob   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_nxt;
      if (w_state == W_IDLE && bus.AW_VALID) begin
        w_idx   <= bus.AW_ADDR[IDXW+1:2];
        w_len   <= bus.AW_LEN;
        w_fixed <= (bus.AW_BURST == 2'b00);
        w_oob   <= aw_oob;
        w_err   <= aw_oob;
        w_cnt   <= '0;
      end
      if (w_fire) begin
        // W_LAST must coincide exactly with the LEN-terminated final beat.
        if (w_final != bus.W_LAST) w_err <= 1'b1;
        w_cnt <= w_cnt + 1'b1;
        if (!w_fixed) w_idx <= w_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_fire && !w_oob) mem[w_idx] <= bus.W_DATA;
  end

  assign bus.AW_READY = (w_state == W_IDLE);
  assign bus.W_READY  = (w_state == W_DATA);
  assign bus.B_VALID  = (w_state == W_RESP);
  assign bus.BRESP    = {w_err, 1'b0};
endmodule

// File: doc/ace_mem_slave.md
Name: ace_mem_slave

Overview:
- Interconnect-side memory target sitting directly downstream of the cache's ACE master port.
- Consumes the AR/R and AW/W/B channels the cache drives and answers from an internal word array.
- Replaces the behavioural interconnect model used in the top-level bench with synthesizable, cycle-defined RTL.
- Read and write paths are independent FSMs sharing one storage array (one write port, one read port).

Parameters:
- WIDTH_A, 32, address width.
- WIDTH_D, 32, data width. Fixed at 32; one word per beat.
- DEPTH_WORDS, 256, array depth in words. Power of two.
- RD_LATENCY, 2, cycles from AR handshake to first R_VALID. Must be at least 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- AR_VALID  in  1  read address valid
- AR_READY  out  1  read address ready
- AR_ADDR  in  WIDTH_A  read byte address
- AR_ID  in  1  read ID
- AR_LEN  in  8  beats minus 1
- AR_BURST  in  2  00 FIXED, 01 INCR, other values treated as INCR
- AR_SNOOP  in  4  accepted, ignored
- R_VALID  out  1  read data valid
- R_READY  in  1  read data ready
- RDATA  out  WIDTH_D  read data
- RRESP  out  4  [1:0] resp, [2] PassDirty, [3] IsShared
- R_LAST  out  1  final beat
- R_ID  out  1  echoed AR_ID
- AW_VALID  in  1  write address valid
- AW_READY  out  1  write address ready
- AW_ADDR  in  WIDTH_A  write byte address
- AW_ID  in  1  write ID
- AW_LEN  in  8  beats minus 1
- AW_BURST  in  2  same encoding as AR_BURST
- AW_SNOOP  in  3  accepted, ignored
- W_VALID  in  1  write data valid
- W_READY  out  1  write data ready
- W_DATA  in  WIDTH_D  write data
- W_LAST  in  1  final write beat
- B_VALID  out  1  write response valid
- B_READY  in  1  write response ready
- BRESP  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Reset values: AR_READY=1, AW_READY=1; all other outputs 0. Both FSMs go to IDLE, beat and latency counters clear.
- Reset aborts any in-flight burst. Array contents are retained, not cleared.
- Word index = ADDR[log2(DEPTH_WORDS)+1:2]. Bits [1:0] are ignored.
- Beat address: FIXED keeps the start address; INCR adds 1 word per beat and wraps modulo DEPTH_WORDS.

Read FSM (R_IDLE, R_WAIT, R_DATA):
- R_IDLE: AR_READY=1. On AR_VALID&&AR_READY at edge N, latch ADDR, ID, LEN and BURST; AR_READY drops; go to R_WAIT.
- R_WAIT: latency counter runs so that R_VALID rises at edge N+RD_LATENCY; go to R_DATA.
- R_DATA:
  - RDATA is the array word at the current beat address, captured when the beat is presented.
  - RDATA, RRESP, R_LAST and R_ID stay stable while R_VALID=1 and R_READY=0.
  - R_LAST=1 when the beat count equals LEN.
  - On handshake of a non-last beat, the next beat is valid on the following cycle.
  - On handshake of the last beat: R_VALID=0, AR_READY=1 the next cycle, return to R_IDLE.
- RRESP=4'b0000 (OKAY, unique clean) by default.

Write FSM (W_IDLE, W_DATA, W_RESP):
- W_IDLE: AW_READY=1. On AW handshake, latch fields; AW_READY drops; W_READY=1 from the next cycle.
- W_DATA: each W handshake writes W_DATA to the array at that edge.
  - Beat count reaching AW_LEN ends the burst regardless of W_LAST.
  - W_LAST low on the final beat, or high on an earlier beat, sets BRESP=10. All beats are still written.
  - After the final beat, W_READY=0; go to W_RESP.
- W_RESP: B_VALID=1 the cycle after the final beat, held until B_READY. Then B_VALID=0, AW_READY=1, return to W_IDLE.

Read/write interaction:
- A read beat presented after the edge on which a write committed returns the new data.
- If a read beat is captured on the same edge as a write to the same word, it returns the old data.
- Simultaneous AR and AW handshakes are both accepted; there is no arbitration stall.

Optional Feature:
- ACE_MEM_ADDR_CHECK_EN, defined:
  - A burst whose start address is at or above DEPTH_WORDS*4 returns RRESP[1:0]=10 on every beat with RDATA=0, or BRESP=10.
  - Writes in such a burst are discarded.
  - Beat address wrap within an in-range burst is unchanged.
- Not defined: upper address bits are ignored, address aliases modulo the depth, and no SLVERR is raised for range.

Test Plan:
- Reset, then AW 0x10 LEN=0, W 0xFEEDBEEF with W_LAST=1 -> B_VALID the cycle after the W handshake, BRESP=00. AR 0x10 LEN=0 -> R_VALID at AR edge+2, RDATA=0xFEEDBEEF, R_LAST=1.
- AW 0x18 INCR LEN=3 writing 1,2,3,4; AR 0x18 INCR LEN=3 with R_READY low for 3 cycles on beat 2 -> RDATA 1,2,3,4 in order, beat 2 held stable, R_LAST only on beat 4.
- AW 0x3FC INCR LEN=1 (DEPTH=256), data A then B -> word 255=A, word 0=B; a readback of each confirms.
- Write burst LEN=1 with W_LAST=1 on beat 0 -> both words written, BRESP=10, back to W_IDLE.
- Assert rst mid read burst after beat 1 -> next cycle R_VALID=0, AR_READY=1; a subsequent read of previously written data is intact.
- With ACE_MEM_ADDR_CHECK_EN: AR 0x400 -> RRESP=0010, RDATA=0. AW 0x400 -> BRESP=10 and word 0 is unchanged.
